fifo_frame_reader: RTL and testbench

Drains the 8-bit, 1024-deep byte buffer FIFO on the Ethernet TX path and turns its contents into length-announced frames for the UDP transmit stage. It keeps a local fill count from a tap of the FIFO write strobe and starts a frame when PKT_LEN bytes are queued, or when a partial load has sat idle for TIMEOUT cycles. It then streams exactly that many bytes on a valid/ready interface. Internal credit tracking and a skid buffer absorb the FIFO's 2-cycle registered read latency.

---
 rtl/fifo_frame_reader.sv | 172 +++++++++++++++++
 tb/tb_fifo_frame_reader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_frame_reader.sv
// Drains the TX byte FIFO into length-announced frames; first m_valid lands RD_LATENCY+1 cycles after frame_start.
// Reads are credit-limited to SKID_DEPTH outstanding bytes, so m_ready backpressure never overflows the skid buffer.
module fifo_frame_reader #(
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH_WIDTH = 10,
   parameter int PKT_LEN     = 256,
   parameter int TIMEOUT     = 1000,
   parameter int RD_LATENCY  = 2,
   parameter int SKID_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_wr_en,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_rd_empty,
   output logic                  frame_start,
   output logic [15:0]           frame_len,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   input  logic                  m_ready
);

   localparam int LW  = DEPTH_WIDTH + 1;
   localparam int TW  = $clog2(TIMEOUT + 1);
   localparam int PW  = $clog2(SKID_DEPTH);
   localparam int SCW = $clog2(SKID_DEPTH + 1);
   localparam int CW  = $clog2(SKID_DEPTH + RD_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, START, STREAM} state_t;

   state_t                 state_q, state_d;
   logic [LW-1:0]          lvl_q, lvl_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic                   frame_start_q, frame_start_d;
   logic [15:0]            frame_len_q, frame_len_d;
   logic [15:0]            req_left_q, req_left_d;
   logic [15:0]            sent_q, sent_d;
   logic [RD_LATENCY-1:0]  pipe_q, pipe_d;
   logic [DATA_WIDTH-1:0]  skid_mem_q [SKID_DEPTH];
   logic [DATA_WIDTH-1:0]  skid_mem_d [SKID_DEPTH];
   logic [PW-1:0]          skid_wp_q, skid_wp_d;
   logic [PW-1:0]          skid_rp_q, skid_rp_d;
   logic [SCW-1:0]         skid_cnt_q, skid_cnt_d;

   logic          rd_issue;
   logic          push;
   logic          pop;
   logic          full_pkt;
   logic          flush;
   logic          lvl_chg;
   logic [CW-1:0] credit_used;

   assign frame_start = frame_start_q;
   assign frame_len   = frame_len_q;
   assign m_valid     = (skid_cnt_q != '0);
   assign m_data      = skid_mem_q[skid_rp_q];
   assign m_last      = m_valid && (sent_q == frame_len_q - 16'd1);
   assign fifo_rd_en  = rd_issue;

   always_comb begin
      credit_used = CW'(skid_cnt_q);
      for (int i = 0; i < RD_LATENCY; i++) begin
         credit_used = credit_used + CW'(pipe_q[i]);
      end
      // Reads may start in START: req_left is already loaded there, which saves a cycle of latency
      rd_issue = (state_q != IDLE) && (req_left_q != 16'd0) && (lvl_q != '0) &&
                 !fifo_rd_empty && (credit_used < CW'(SKID_DEPTH));
      push     = pipe_q[RD_LATENCY-1];
      pop      = m_valid && m_ready;
      full_pkt = (lvl_q >= LW'(PKT_LEN));
      lvl_chg  = fifo_wr_en ^ rd_issue;
      flush    = (state_q == IDLE) && (lvl_q != '0) && !full_pkt && (timer_q == TW'(TIMEOUT - 1));

      lvl_d = lvl_q + LW'(fifo_wr_en) - LW'(rd_issue);

      timer_d = timer_q;
      if ((state_q != IDLE) || (lvl_q == '0) || full_pkt || lvl_chg) begin
         timer_d = '0;
      end else if (timer_q != TW'(TIMEOUT - 1)) begin
         timer_d = timer_q + TW'(1);
      end

      pipe_d[0] = rd_issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end

      skid_mem_d = skid_mem_q;
      skid_wp_d  = skid_wp_q;
      skid_rp_d  = skid_rp_q;
      if (push) begin
         skid_mem_d[skid_wp_q] = fifo_rd_data;
         skid_wp_d = (skid_wp_q == PW'(SKID_DEPTH - 1)) ? '0 : skid_wp_q + PW'(1);
      end
      if (pop) begin
         skid_rp_d = (skid_rp_q == PW'(SKID_DEPTH - 1)) ? '0 : skid_rp_q + PW'(1);
      end
      skid_cnt_d = skid_cnt_q + SCW'(push) - SCW'(pop);

      state_d       = state_q;
      frame_start_d = 1'b0;
      frame_len_d   = frame_len_q;
      req_left_d    = req_left_q;
      sent_d        = sent_q;
      case (state_q)
         IDLE: begin
            if (full_pkt) begin
               state_d       = START;
               frame_start_d = 1'b1;
               frame_len_d   = 16'(PKT_LEN);
               req_left_d    = 16'(PKT_LEN);
               sent_d        = 16'd0;
            end else if (flush) begin
               state_d       = START;
               frame_start_d = 1'b1;
               frame_len_d   = 16'(lvl_q);
               req_left_d    = 16'(lvl_q);
               sent_d        = 16'd0;
            end
         end
         START:   state_d = STREAM;
         STREAM:  state_d = STREAM;
         default: state_d = IDLE;
      endcase

      if (rd_issue) begin
         req_left_d = req_left_q - 16'd1;
      end
      if (pop) begin
         sent_d = sent_q + 16'd1;
         if (m_last) begin
            sent_d  = 16'd0;
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         lvl_q         <= '0;
         timer_q       <= '0;
         frame_start_q <= 1'b0;
         frame_len_q   <= 16'd0;
         req_left_q    <= 16'd0;
         sent_q        <= 16'd0;
         pipe_q        <= '0;
         skid_wp_q     <= '0;
         skid_rp_q     <= '0;
         skid_cnt_q    <= '0;
         for (int i = 0; i < SKID_DEPTH; i++) begin
            skid_mem_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         lvl_q         <= lvl_d;
         timer_q       <= timer_d;
         frame_start_q <= frame_start_d;
         frame_len_q   <= frame_len_d;
         req_left_q    <= req_left_d;
         sent_q        <= sent_d;
         pipe_q        <= pipe_d;
         skid_wp_q     <= skid_wp_d;
         skid_rp_q     <= skid_rp_d;
         skid_cnt_q    <= skid_cnt_d;
         skid_mem_q    <= skid_mem_d;
      end
   end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Bench for fifo_frame_reader: behavioural 2-cycle-latency FIFO, byte/length scoreboard, directed scenarios.
module tb_fifo_frame_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fifo_wr_en = 1'b0;
   logic [7:0]  wdata = 8'd0;
   logic        fifo_rd_en;
   logic [7:0]  fifo_rd_data;
   logic        fifo_rd_empty;
   logic        frame_start;
   logic [15:0] frame_len;
   logic        m_valid;
   logic [7:0]  m_data;
   logic        m_last;
   logic        m_ready = 1'b1;

   fifo_frame_reader dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fifo_wr_en    (fifo_wr_en),
      .fifo_rd_en    (fifo_rd_en),
      .fifo_rd_data  (fifo_rd_data),
      .fifo_rd_empty (fifo_rd_empty),
      .frame_start   (frame_start),
      .frame_len     (frame_len),
      .m_valid       (m_valid),
      .m_data        (m_data),
      .m_last        (m_last),
      .m_ready       (m_ready)
   );

   always #5 clk = ~clk;

   // FIFO model: registered RAM read plus output register
   logic [7:0] mem [1024];
   int         wp, rp, cnt;
   logic [7:0] s1, s2;
   assign fifo_rd_empty = (cnt == 0);
   assign fifo_rd_data  = s2;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp <= 0; rp <= 0; cnt <= 0; s1 <= 8'd0; s2 <= 8'd0;
      end else begin
         if (fifo_wr_en) begin
            mem[wp] <= wdata;
            wp <= (wp + 1) % 1024;
         end
         if (fifo_rd_en) begin
            s1 <= mem[rp];
            rp <= (rp + 1) % 1024;
         end
         s2  <= s1;
         cnt <= cnt + int'(fifo_wr_en) - int'(fifo_rd_en);
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   logic [7:0] exp_q [$];
   int         len_q [$];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   frames_started = 0, frames_done = 0;
   int   cur_len = 0, bcnt = 0, fs_cyc = 0, last_end = -100;
   int   outst = 0, rd_cnt = 0, rd_in_frame = 0, gap_cnt = 0;
   bit   first_seen = 1'b0, hold_pend = 1'b0, frame_act = 1'b0;
   logic [7:0] prev_dat = 8'd0;

   always @(negedge clk) begin
      if (!rst_n) begin
         frame_act = 1'b0; hold_pend = 1'b0; outst = 0; bcnt = 0; first_seen = 1'b1;
      end else begin
         if (frame_start) begin
            frames_started++;
            if (len_q.size() == 0) chk("unexpected_frame", 1, 0);
            else begin
               cur_len = len_q.pop_front();
               chk("frame_len", frame_len, cur_len);
            end
            chk("idle_gap", int'(cyc - last_end >= 2), 1);
            fs_cyc = cyc; bcnt = 0; first_seen = 1'b0; rd_in_frame = 0; frame_act = 1'b1;
         end
         if (fifo_rd_en) begin
            chk("rd_nonempty", fifo_rd_empty, 0);
            rd_cnt++; rd_in_frame++; outst++;
            chk("outstanding_le4", int'(outst <= 4), 1);
         end else if (frame_act && rd_in_frame > 0 && rd_in_frame < cur_len) begin
            gap_cnt++;
         end
         if (m_valid && !first_seen) begin
            chk("first_valid_lat", cyc - fs_cyc, 3);
            first_seen = 1'b1;
         end
         if (hold_pend) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, prev_dat);
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("extra_byte", 1, 0);
            else chk("m_data", m_data, exp_q.pop_front());
            chk("m_last", m_last, int'(bcnt == cur_len - 1));
            bcnt++; outst--;
            if (m_last) begin
               frames_done++; last_end = cyc; frame_act = 1'b0;
            end
         end
         hold_pend = m_valid && !m_ready;
         prev_dat  = m_data;
      end
   end

   // m_ready driver: 0 = always ready, 1 = stalled, 2 = repeating 1,0,0,1
   int rdy_mode = 0;
   int ph = 0;
   initial begin
      forever begin
         @(posedge clk); #1;
         ph++;
         case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'b0;
            default: m_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
         endcase
      end
   end

   task automatic write_n(input int n, input int mode, input int base);
      for (int i = 0; i < n; i++) begin
         case (mode)
            0:       wdata = 8'(255 - i);
            1:       wdata = 8'(base + i);
            default: wdata = 8'($urandom);
         endcase
         exp_q.push_back(wdata);
         fifo_wr_en = 1'b1;
         @(posedge clk); #1;
      end
      fifo_wr_en = 1'b0;
   endtask

   task automatic wait_done(input int n, input int budget, input string tag);
      int k;
      k = 0;
      while (frames_done < n && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      chk(tag, int'(frames_done >= n), 1);
   endtask

   int wend, r0, k;

   initial begin
      #1;
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_frame_len", frame_len, 0);
      chk("rst_m_data", m_data, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // 256 bytes FF..00, full-rate drain
      gap_cnt = 0;
      len_q.push_back(256);
      write_n(256, 0, 0);
      wait_done(1, 400, "t1_done");
      chk("t1_no_rd_gaps", gap_cnt, 0);
      chk("t1_all_bytes", exp_q.size(), 0);

      // 5-byte partial frame flushed by the idle timer
      len_q.push_back(5);
      write_n(5, 2, 0);
      wend = cyc;
      wait_done(2, 1200, "t2_done");
      chk("t2_flush_lat", fs_cyc - wend, 1000);
      @(posedge clk); #1;
      chk("t2_lvl_zero", dut.lvl_q, 0);
      repeat (1200) @(posedge clk);
      #1 chk("t2_no_extra_frame", frames_started, 2);

      // stalled consumer 1,0,0,1
      gap_cnt = 0;
      rdy_mode = 2;
      len_q.push_back(256);
      write_n(256, 2, 0);
      wait_done(3, 1500, "t3_done");
      chk("t3_credit_stall", int'(gap_cnt > 0), 1);
      rdy_mode = 0;

      // 600 bytes: two full frames plus an 88-byte flush
      len_q.push_back(256);
      len_q.push_back(256);
      len_q.push_back(88);
      write_n(600, 1, 7);
      wait_done(6, 3000, "t4_done");
      chk("t4_all_bytes", exp_q.size(), 0);

      // FIFO filled while consumer stalled
      rdy_mode = 1;
      @(posedge clk); #1;
      r0 = rd_cnt;
      for (int i = 0; i < 4; i++) len_q.push_back(256);
      write_n(1024, 2, 0);
      repeat (2000) @(posedge clk);
      #1 chk("t5_stall_reads", rd_cnt - r0, 4);
      rdy_mode = 0;
      wait_done(10, 2000, "t5_done");
      chk("t5_all_bytes", exp_q.size(), 0);

      // reset in the middle of a frame
      len_q.push_back(256);
      write_n(256, 2, 0);
      k = 0;
      while (!(frame_act && bcnt >= 100) && k < 600) begin
         @(posedge clk); #1;
         k++;
      end
      chk("t6_reach_byte100", int'(frame_act && bcnt >= 100), 1);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_rd_en", fifo_rd_en, 0);
      chk("t6_rst_m_valid", m_valid, 0);
      chk("t6_rst_m_last", m_last, 0);
      chk("t6_rst_frame_start", frame_start, 0);
      chk("t6_rst_frame_len", frame_len, 0);
      exp_q.delete();
      len_q.delete();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("t6_lvl_zero", dut.lvl_q, 0);
      chk("t6_idle_no_valid", m_valid, 0);
      len_q.push_back(256);
      write_n(256, 2, 0);
      wait_done(11, 600, "t6_clean_frame");
      chk("t6_all_bytes", exp_q.size(), 0);
      chk("frames_total", frames_started, 12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
